// File: rtl/dpi_stream_sequencer_if.sv
// Packet/byte ingress handshake between a packet source and the stream sequencer.
interface dpi_stream_sequencer_if #(
   parameter int KEY_W = 32
);
   logic             pkt_vld;
   logic [KEY_W-1:0] pkt_key;
   logic             pkt_fin;
   logic             pkt_rdy;
   logic             byte_vld;
   logic [7:0]       byte_data;
   logic             byte_last;
   logic             byte_rdy;

   // Packet source side.
   modport master (
      output pkt_vld, pkt_key, pkt_fin, byte_vld, byte_data, byte_last,
      input  pkt_rdy, byte_rdy
   );

   // Sequencer side.
   modport slave (
      input  pkt_vld, pkt_key, pkt_fin, byte_vld, byte_data, byte_last,
      output pkt_rdy, byte_rdy
   );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// Front-end controller for the per-stream regex matcher bank: maps flow keys to stream ids
// through a small fully associative flow table and sequences load / characters / eop.
module dpi_stream_sequencer #(
   parameter int NUM_STREAMS = 64,
   parameter int SID_W       = 6,
   parameter int KEY_W       = 32,
   parameter int NUM_REGEX   = 8,
   parameter int LOAD_GAP    = 2,
   parameter int MATCH_LAT   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   dpi_stream_sequencer_if.slave   s_in,
   input  logic                    cfg_we,
   input  logic [SID_W-1:0]        cfg_sid,
   input  logic [NUM_REGEX-1:0]    cfg_enable,
   output logic                    load_state,
   output logic [SID_W-1:0]        stream_id,
   output logic                    new_stream_id,
   output logic [7:0]              char_in,
   output logic                    char_in_vld,
   output logic                    eop,
   output logic [NUM_REGEX-1:0]    enable,
   output logic                    busy,
   output logic [31:0]             pkt_count,
   output logic [15:0]             evict_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [7:0]             r_cnt;
   logic [KEY_W-1:0]       r_pkt_key;
   logic                   r_pkt_fin;

   logic [NUM_STREAMS-1:0] r_valid;
   logic [KEY_W-1:0]       r_key  [NUM_STREAMS];
   logic [NUM_REGEX-1:0]   r_mask [NUM_STREAMS];
   logic [SID_W-1:0]       r_evict_ptr;

   logic                   w_hit, w_free, w_new, w_evict;
   logic [SID_W-1:0]       w_hit_idx, w_free_idx, w_sid;

   logic                   r_load_state, r_new_stream_id, r_char_in_vld, r_eop;
   logic [7:0]             r_char_in;
   logic [SID_W-1:0]       r_stream_id;
   logic [NUM_REGEX-1:0]   r_enable;
   logic [31:0]            r_pkt_count;
   logic [15:0]            r_evict_count;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; GAP and DRAIN are timed by r_cnt.
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (s_in.pkt_vld) w_state_nxt = S_LOOKUP;
         S_LOOKUP: w_state_nxt = S_LOAD;
         S_LOAD:   w_state_nxt = S_GAP;
         S_GAP:    if (r_cnt == 8'(LOAD_GAP - 1)) w_state_nxt = S_STREAM;
         S_STREAM: if (s_in.byte_vld && s_in.byte_last) w_state_nxt = S_DRAIN;
         S_DRAIN:  if (r_cnt == 8'(MATCH_LAT - 1)) w_state_nxt = S_EOP;
         S_EOP:    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Combinational handshake outputs; pkt_rdy is held low while reset is asserted.
   always_comb begin
      s_in.pkt_rdy  = rst_n && (r_state == S_IDLE);
      s_in.byte_rdy = (r_state == S_STREAM);
      busy          = (r_state != S_IDLE);
   end

   // Cycle counter for GAP and DRAIN; restarts on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_cnt <= '0;
      else if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state == S_GAP || r_state == S_DRAIN) r_cnt <= r_cnt + 8'd1;
   end

   // Latch the accepted packet header.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_key <= '0;
         r_pkt_fin <= 1'b0;
      end else if (r_state == S_IDLE && s_in.pkt_vld) begin
         r_pkt_key <= s_in.pkt_key;
         r_pkt_fin <= s_in.pkt_fin;
      end
   end

   // Parallel lookup; descending scan so the lowest matching / free index wins.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
         if (r_valid[i] && r_key[i] == r_pkt_key) begin
            w_hit     = 1'b1;
            w_hit_idx = SID_W'(i);
         end
         if (!r_valid[i]) begin
            w_free     = 1'b1;
            w_free_idx = SID_W'(i);
         end
      end
      w_new   = !w_hit;
      w_evict = !w_hit && !w_free;
      w_sid   = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_evict_ptr);
   end

   // Entry valid bits: set on allocation, cleared when a finishing flow completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_valid <= '0;
      else if (r_state == S_LOOKUP)              r_valid[w_sid] <= 1'b1;
      else if (r_state == S_EOP && r_pkt_fin)    r_valid[r_stream_id] <= 1'b0;
   end

   // Key storage written on allocation.
   always_ff @(posedge clk) begin
      // NOTE: keys need no reset; r_valid gates every compare, so stale keys are never seen.
      if (r_state == S_LOOKUP) r_key[w_sid] <= r_pkt_key;
   end

   // Per-stream enable masks, written by the configuration port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_STREAMS; i++) r_mask[i] <= '0;
      end else if (cfg_we) begin
         r_mask[cfg_sid] <= cfg_enable;
      end
   end

   // Eviction pointer and saturating eviction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evict_ptr   <= '0;
         r_evict_count <= '0;
      end else if (r_state == S_LOOKUP && w_evict) begin
         r_evict_ptr <= (r_evict_ptr == SID_W'(NUM_STREAMS - 1)) ? '0 : r_evict_ptr + SID_W'(1);
         if (r_evict_count != 16'hFFFF) r_evict_count <= r_evict_count + 16'd1;
      end
   end

   // Registered matcher-side outputs and packet counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_state    <= 1'b0;
         r_new_stream_id <= 1'b0;
         r_eop           <= 1'b0;
         r_char_in_vld   <= 1'b0;
         r_char_in       <= '0;
         r_stream_id     <= '0;
         r_enable        <= '0;
         r_pkt_count     <= '0;
      end else begin
         r_load_state    <= (w_state_nxt == S_LOAD);
         r_new_stream_id <= (w_state_nxt == S_LOAD) && w_new;
         r_eop           <= (w_state_nxt == S_EOP);
         r_char_in_vld   <= (r_state == S_STREAM) && s_in.byte_vld;
         if (r_state == S_STREAM && s_in.byte_vld) r_char_in <= s_in.byte_data;
         if (r_state == S_LOOKUP) begin
            r_stream_id <= w_sid;
            r_enable    <= r_mask[w_sid];
         end
         if (r_state == S_EOP) r_pkt_count <= r_pkt_count + 32'd1;
      end
   end

   assign load_state    = r_load_state;
   assign new_stream_id = r_new_stream_id;
   assign eop           = r_eop;
   assign char_in_vld   = r_char_in_vld;
   assign char_in       = r_char_in;
   assign stream_id     = r_stream_id;
   assign enable        = r_enable;
   assign pkt_count     = r_pkt_count;
   assign evict_count   = r_evict_count;

endmodule
